// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its IFB entry format.
// No logic; IFB entry is {2'b0, status[2:0], 1'b0, instr[31:0]}.
// Status codes distinguish clean fetches from bus errors.
package p_hardisc;

    localparam int IFB_WIDTH = 38;

    localparam logic [2:0] FETCH_VALID = 3'b001;
    localparam logic [2:0] FETCH_BSERR = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fsq_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_secded.sv
// SECDED (Hamming 38,32 plus overall parity) check bits for a 32-bit word; built only with IFB_CHECKSUM_EN.
// Latency: combinational.
// Backpressure: none.
`ifdef IFB_CHECKSUM_EN
module secded_encode (
    input  logic [31:0] data,
    output logic [6:0]  checksum
);

    logic [5:0] hp;

    // Data bits occupy the non-power-of-two codeword positions 3,5,6,7,9,...
    always_comb begin
        int di;
        hp = '0;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int b = 0; b < 6; b++) begin
                    if (pos[b]) hp[b] = hp[b] ^ data[di];
                end
                di++;
            end
        end
        checksum = {^{data, hp}, hp};
    end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word fetches on the bus and pushes responses into the IFB; IFB_CHECKSUM_EN adds SECDED.
// Latency: response to IFB push is combinational (0 cycles); request issues the cycle after start/redirect.
// Backpressure: requests are throttled by free IFB slots and MAX_OUTST in-flight fetches.
module fetch_sequencer
    import p_hardisc::*;
#(
    parameter int SIZE      = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                 s_clk_i,
    input  logic                 s_rst_i,
    input  logic                 s_start_i,
    input  logic [31:0]          s_boot_addr_i,
    input  logic                 s_redirect_i,
    input  logic [31:0]          s_redirect_addr_i,
    input  logic [SIZE-1:0]      s_ifb_occupied_i,
    input  logic                 s_ifb_pop_i,
    output logic                 s_bus_req_o,
    output logic [31:0]          s_bus_addr_o,
    input  logic                 s_bus_gnt_i,
    input  logic                 s_bus_rvalid_i,
    input  logic [31:0]          s_bus_rdata_i,
    input  logic                 s_bus_err_i,
    output logic                 s_push_o,
    output logic [IFB_WIDTH-1:0] s_data_o,
    output logic [6:0]           s_checksum_o,
    output logic                 s_flush_o,
    output logic [1:0]           s_outst_o
);

    fsq_state_t  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [1:0]  outst, outst_nxt;
    logic [1:0]  discard, discard_nxt;
    logic [31:0] occ_cnt, free;
    logic        grant, rsp;

    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            state   <= IDLE;
            pc      <= '0;
            outst   <= '0;
            discard <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            outst   <= outst_nxt;
            discard <= discard_nxt;
        end
    end

    // A slot popped this cycle can already be refilled by this cycle's request.
    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            occ_cnt = occ_cnt + 32'(s_ifb_occupied_i[i]);
        end
        free = 32'(SIZE) - occ_cnt + 32'(s_ifb_pop_i);
    end

    always_comb begin
        s_bus_req_o  = (state == FETCH) && !s_redirect_i
                       && (32'(outst) < 32'(MAX_OUTST)) && (32'(outst) < free);
        s_bus_addr_o = pc;
        s_outst_o    = outst;
        s_flush_o    = s_redirect_i && !s_rst_i;

        grant = s_bus_req_o && s_bus_gnt_i;
        rsp   = s_bus_rvalid_i && (outst != 2'd0);

        s_push_o = rsp && !s_redirect_i && (discard == 2'd0);
        s_data_o = '0;
        if (s_push_o) begin
            s_data_o = {2'b00, (s_bus_err_i ? FETCH_BSERR : FETCH_VALID), 1'b0, s_bus_rdata_i};
        end

        outst_nxt = outst;
        if (grant && !rsp && (32'(outst) < 32'(MAX_OUTST))) begin
            outst_nxt = outst + 2'd1;
        end else if (!grant && rsp) begin
            outst_nxt = outst - 2'd1;
        end

        // On redirect every fetch still owed by the bus belongs to the old stream.
        discard_nxt = discard;
        if (s_redirect_i) begin
            discard_nxt = outst - {1'b0, rsp};
        end else if (rsp && (discard != 2'd0)) begin
            discard_nxt = discard - 2'd1;
        end

        state_nxt = state;
        pc_nxt    = pc;
        if (grant) begin
            pc_nxt = pc + 32'd4;
        end
        unique case (state)
            IDLE: begin
                if (s_start_i) begin
                    state_nxt = FETCH;
                    pc_nxt    = word_align(s_boot_addr_i);
                end
            end
            FETCH: begin
                if (s_push_o && s_bus_err_i) state_nxt = HOLD;
            end
            HOLD: ;
            default: state_nxt = IDLE;
        endcase
        if (s_redirect_i) begin
            state_nxt = FETCH;
            pc_nxt    = word_align(s_redirect_addr_i);
        end
    end

`ifdef IFB_CHECKSUM_EN
    secded_encode u_secded (
        .data     (s_data_o[31:0]),
        .checksum (s_checksum_o)
    );
`else
    assign s_checksum_o = '0;
`endif

    gnt_needs_req: assert property (@(posedge s_clk_i) disable iff (s_rst_i)
        s_bus_gnt_i |-> s_bus_req_o);
    rvalid_needs_outst: assert property (@(posedge s_clk_i) disable iff (s_rst_i)
        s_bus_rvalid_i |-> (outst != 2'd0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-based model of the bus and IFB.
// Directed boot/pop/error/redirect/wrap sequences followed by a long random run with occasional resets.
module tb_fetch_sequencer;
    import p_hardisc::*;

    localparam int SIZE      = 2;
    localparam int MAX_OUTST = 2;

    logic                 s_clk_i = 1'b0;
    logic                 s_rst_i = 1'b1;
    logic                 s_start_i = 1'b0;
    logic [31:0]          s_boot_addr_i = '0;
    logic                 s_redirect_i = 1'b0;
    logic [31:0]          s_redirect_addr_i = '0;
    logic [SIZE-1:0]      s_ifb_occupied_i = '0;
    logic                 s_ifb_pop_i = 1'b0;
    logic                 s_bus_req_o;
    logic [31:0]          s_bus_addr_o;
    logic                 s_bus_gnt_i = 1'b0;
    logic                 s_bus_rvalid_i = 1'b0;
    logic [31:0]          s_bus_rdata_i = '0;
    logic                 s_bus_err_i = 1'b0;
    logic                 s_push_o;
    logic [IFB_WIDTH-1:0] s_data_o;
    logic [6:0]           s_checksum_o;
    logic                 s_flush_o;
    logic [1:0]           s_outst_o;

    always #5 s_clk_i = ~s_clk_i;

    fetch_sequencer #(.SIZE(SIZE), .MAX_OUTST(MAX_OUTST)) dut (
        .s_clk_i           (s_clk_i),
        .s_rst_i           (s_rst_i),
        .s_start_i         (s_start_i),
        .s_boot_addr_i     (s_boot_addr_i),
        .s_redirect_i      (s_redirect_i),
        .s_redirect_addr_i (s_redirect_addr_i),
        .s_ifb_occupied_i  (s_ifb_occupied_i),
        .s_ifb_pop_i       (s_ifb_pop_i),
        .s_bus_req_o       (s_bus_req_o),
        .s_bus_addr_o      (s_bus_addr_o),
        .s_bus_gnt_i       (s_bus_gnt_i),
        .s_bus_rvalid_i    (s_bus_rvalid_i),
        .s_bus_rdata_i     (s_bus_rdata_i),
        .s_bus_err_i       (s_bus_err_i),
        .s_push_o          (s_push_o),
        .s_data_o          (s_data_o),
        .s_checksum_o      (s_checksum_o),
        .s_flush_o         (s_flush_o),
        .s_outst_o         (s_outst_o)
    );

    // One entry per fetch the bus has accepted but not yet answered.
    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          stale;
        bit          err;
        logic [31:0] data;
    } fetch_t;

    fetch_t      q[$];
    int          m_state;          // 0 idle, 1 fetching, 2 halted on error
    logic [31:0] m_pc;
    int          occ;
    int          cyc;
    int          gnt_pct, rv_pct, pop_pct, err_pct;
    logic [31:0] err_addr;
    logic [31:0] req_addrs[$];
    int          n_push;
    logic [IFB_WIDTH-1:0] last_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

`ifdef IFB_CHECKSUM_EN
    function automatic logic [6:0] ref_secded(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  c;
        int          k;
        cw = '0;
        k  = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!$onehot(pos)) begin
                cw[pos] = d[k];
                k++;
            end
        end
        c = '0;
        for (int i = 0; i < 6; i++)
            for (int pos = 1; pos <= 38; pos++)
                if (((pos >> i) & 1) == 1) c[i] = c[i] ^ cw[pos];
        c[6] = (^cw) ^ (^c[5:0]);
        return c;
    endfunction
`endif

    task automatic do_cycle(input bit start, input logic [31:0] boot,
                            input bit redir, input logic [31:0] raddr);
        bit rv, pop, gnt_b, exp_req, exp_push;
        int free;
        fetch_t f;
        logic [IFB_WIDTH-1:0] exp_data;
        logic [6:0] exp_ck;
        @(negedge s_clk_i);
        pop = (occ > 0) && ($urandom_range(99) < pop_pct);
        s_ifb_occupied_i  = SIZE'((1 << occ) - 1);
        s_ifb_pop_i       = pop;
        s_start_i         = start;
        s_boot_addr_i     = boot;
        s_redirect_i      = redir;
        s_redirect_addr_i = raddr;
        rv = (q.size() > 0) && (q[0].cyc < cyc) && ($urandom_range(99) < rv_pct);
        s_bus_rvalid_i = rv;
        s_bus_rdata_i  = rv ? q[0].data : $urandom;
        s_bus_err_i    = rv ? q[0].err : 1'($urandom_range(1));
        s_bus_gnt_i    = 1'b0;
        #1;
        free    = SIZE - occ + int'(pop);
        exp_req = (m_state == 1) && !redir && (q.size() < MAX_OUTST) && (q.size() < free);
        chk("req", s_bus_req_o, exp_req);
        chk("addr", s_bus_addr_o, m_pc);
        gnt_b = s_bus_req_o && exp_req && ($urandom_range(99) < gnt_pct);
        s_bus_gnt_i = gnt_b;
        if (gnt_b) req_addrs.push_back(s_bus_addr_o);
        #1;
        exp_push = rv && !redir && !q[0].stale;
        exp_data = exp_push ? {2'b00, (q[0].err ? FETCH_BSERR : FETCH_VALID), 1'b0, q[0].data} : '0;
`ifdef IFB_CHECKSUM_EN
        exp_ck = ref_secded(exp_data[31:0]);
`else
        exp_ck = '0;
`endif
        chk("push", s_push_o, exp_push);
        chk("data", s_data_o, exp_data);
        chk("checksum", s_checksum_o, exp_ck);
        chk("flush", s_flush_o, redir);
        chk("outst", s_outst_o, q.size());
        if (s_push_o) begin
            n_push++;
            last_data = s_data_o;
        end

        if (rv) void'(q.pop_front());
        occ = occ - int'(pop) + int'(exp_push);
        if (redir) begin
            foreach (q[i]) q[i].stale = 1'b1;
            occ     = 0;
            m_state = 1;
            m_pc    = raddr & ~32'd3;
        end else begin
            if (gnt_b) begin
                f.addr  = m_pc;
                f.cyc   = cyc;
                f.stale = 1'b0;
                f.err   = (m_pc == err_addr) || ($urandom_range(99) < err_pct);
                f.data  = (m_pc == 32'h100) ? 32'h0000_0013 : $urandom;
                q.push_back(f);
                m_pc = m_pc + 32'd4;
            end
            if (m_state == 0 && start) begin
                m_state = 1;
                m_pc    = boot & ~32'd3;
            end else if (m_state == 1 && exp_push && exp_data[35:33] == FETCH_BSERR) begin
                m_state = 2;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge s_clk_i);
        s_rst_i        = 1'b1;
        s_bus_rvalid_i = 1'b0;
        s_bus_gnt_i    = 1'b0;
        s_redirect_i   = 1'b1;
        s_start_i      = 1'b1;
        #1;
        chk("rst_req", s_bus_req_o, 1'b0);
        chk("rst_addr", s_bus_addr_o, 32'h0);
        chk("rst_push", s_push_o, 1'b0);
        chk("rst_data", s_data_o, '0);
        chk("rst_ck", s_checksum_o, 7'h0);
        chk("rst_flush", s_flush_o, 1'b0);
        chk("rst_outst", s_outst_o, 2'd0);
        q.delete();
        m_state = 0;
        m_pc    = '0;
        occ     = 0;
        @(negedge s_clk_i);
        s_rst_i      = 1'b0;
        s_redirect_i = 1'b0;
        s_start_i    = 1'b0;
    endtask

    initial begin
        cyc = 0; occ = 0; m_state = 0; m_pc = '0; n_push = 0; last_data = '0;
        gnt_pct = 100; rv_pct = 100; pop_pct = 0; err_pct = 0;
        err_addr = 32'h108;
        do_reset();

        // Boot with an empty IFB that is never popped: two fetches fill it.
        req_addrs.delete();
        n_push = 0;
        do_cycle(1'b1, 32'h100, 1'b0, '0);
        repeat (7) do_cycle(1'b0, '0, 1'b0, '0);
        chk("boot_nreq", req_addrs.size(), 2);
        chk("boot_a0", req_addrs[0], 32'h100);
        chk("boot_a1", req_addrs[1], 32'h104);
        chk("boot_npush", n_push, 2);

        // Single pop frees one slot; the refill at 0x108 returns a bus error.
        req_addrs.delete();
        n_push  = 0;
        pop_pct = 100;
        do_cycle(1'b0, '0, 1'b0, '0);
        pop_pct = 0;
        repeat (4) do_cycle(1'b0, '0, 1'b0, '0);
        chk("pop_nreq", req_addrs.size(), 1);
        chk("pop_addr", req_addrs[0], 32'h108);
        chk("err_npush", n_push, 1);
        chk("err_status", last_data[35:33], FETCH_BSERR);
        pop_pct = 100;
        repeat (6) do_cycle(1'b0, '0, 1'b0, '0);
        chk("hold_nreq", req_addrs.size(), 1);

        // Two fetches in flight, then redirect: both answers are dropped.
        rv_pct  = 0;
        pop_pct = 0;
        do_cycle(1'b0, '0, 1'b1, 32'h3000);
        repeat (3) do_cycle(1'b0, '0, 1'b0, '0);
        chk("inflight_nreq", req_addrs.size(), 3);
        req_addrs.delete();
        n_push = 0;
        do_cycle(1'b0, '0, 1'b1, 32'h2000);
        rv_pct = 100;
        repeat (2) do_cycle(1'b0, '0, 1'b0, '0);
        chk("discard_npush", n_push, 0);
        repeat (4) do_cycle(1'b0, '0, 1'b0, '0);
        chk("redir_first", req_addrs[0], 32'h2000);

        // PC wraps from the top of the address space to zero.
        pop_pct = 100;
        do_cycle(1'b0, '0, 1'b1, 32'hFFFF_FFF8);
        req_addrs.delete();
        repeat (10) do_cycle(1'b0, '0, 1'b0, '0);
        chk("wrap_a0", req_addrs[0], 32'hFFFF_FFF8);
        chk("wrap_a1", req_addrs[1], 32'hFFFF_FFFC);
        chk("wrap_a2", req_addrs[2], 32'h0000_0000);

        // Random traffic with redirects, starts, errors and occasional resets.
        gnt_pct  = 70;
        rv_pct   = 60;
        pop_pct  = 50;
        err_pct  = 5;
        err_addr = 32'h1;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(999);
            if (r < 3) do_reset();
            else do_cycle(r < 100, $urandom, r >= 950, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter SIZE, default 2: number of IFB entries the block feeds.
REQ-002 Parameter MAX_OUTST, default 2: maximum fetches in flight on the bus, 1..3.
REQ-003 s_clk_i  in  1  the block's only clock; all state updates on its rising edge.
REQ-004 s_rst_i  in  1  asynchronous, active-high reset.
REQ-005 s_start_i  in  1  begin fetching from s_boot_addr_i.
REQ-006 s_boot_addr_i  in  32  boot address.
REQ-007 s_redirect_i  in  1  pipeline redirect.
REQ-008 s_redirect_addr_i  in  32  redirect target.
REQ-009 s_ifb_occupied_i  in  SIZE  IFB per-entry occupancy.
REQ-010 s_ifb_pop_i  in  1  IFB pops an entry this cycle.
REQ-011 s_bus_req_o  out  1  address-phase request.
REQ-012 s_bus_addr_o  out  32  fetch address, word aligned.
REQ-013 s_bus_gnt_i  in  1  address phase accepted.
REQ-014 s_bus_rvalid_i  in  1  response valid.
REQ-015 s_bus_rdata_i  in  32  response data.
REQ-016 s_bus_err_i  in  1  response error, qualified by s_bus_rvalid_i.
REQ-017 s_push_o  out  1  push to the IFB.
REQ-018 s_data_o  out  IFB_WIDTH  IFB entry: [31:0] instruction, [32] 0, [35:33] fetch status, [37:36] 0.
REQ-019 s_checksum_o  out  7  SECDED checksum of s_data_o[31:0].
REQ-020 s_flush_o  out  1  IFB flush; equals s_redirect_i.
REQ-021 s_outst_o  out  2  current in-flight count.

Function
REQ-022 The FSM SHALL have states IDLE, FETCH and HOLD.
- IDLE -> FETCH on s_start_i: fetch PC loads s_boot_addr_i.
- FETCH -> HOLD on an accepted (non-discarded) error response.
- Any state -> FETCH on s_redirect_i: fetch PC loads s_redirect_addr_i.
REQ-023 free = SIZE - popcount(s_ifb_occupied_i) + s_ifb_pop_i; s_bus_req_o SHALL be high only in FETCH, without s_redirect_i, while outst < MAX_OUTST and outst < free.
REQ-024 The fetch PC SHALL advance by 4 on the cycle s_bus_req_o & s_bus_gnt_i, with 32-bit wrap from 0xFFFFFFFC to 0; s_bus_addr_o equals the PC.
REQ-025 outst SHALL be +1 on grant and -1 on rvalid; both in one cycle leave it unchanged.
REQ-026 Responses SHALL arrive in order, one cycle minimum after grant; a non-discarded rvalid SHALL push in the same cycle (combinational, 0-cycle latency).
REQ-027 Status SHALL be FETCH_VALID on a clean response and FETCH_BSERR on an error response; rdata passes unchanged.
REQ-028 On s_redirect_i, the discard counter SHALL load the outstanding fetches not completing in that cycle; each later rvalid while discard>0 decrements it and SHALL NOT push.
REQ-029 An rvalid coinciding with s_redirect_i SHALL NOT push.
REQ-030 A redirect during discard SHALL reload the discard counter per REQ-028; responses are never lost from the count.
REQ-031 s_start_i outside IDLE SHALL be ignored.
REQ-032 A grant without request, or rvalid at outst=0, is illegal; assertions flag it, and counters saturate at 0/MAX_OUTST.

Reset
REQ-033 Reset SHALL force: IDLE, PC=0, outst=0, discard=0.
REQ-034 Reset SHALL force all outputs low/zero.
REQ-035 Reset asserted mid-transfer SHALL drop in-flight responses without pushes; the bus agent shares the reset.

Configuration
REQ-036 Macro IFB_CHECKSUM_EN defined: s_checksum_o is the SECDED encoding of s_data_o[31:0].
REQ-037 Macro IFB_CHECKSUM_EN undefined: s_checksum_o is tied to 0 and no encoder is instantiated.

Structure
REQ-038 Package p_hardisc SHALL hold IFB_WIDTH, FETCH_VALID, FETCH_BSERR, and the FSM state enum fsq_state_t.
REQ-039 Sub-module secded_encode, instantiated only under IFB_CHECKSUM_EN; all else is inline.

Verification
REQ-040 Start, boot 0x100, always-grant, 1-cycle responses, IFB empty, never popped -> exactly 2 requests (0x100, 0x104), 2 pushes, requests stop.
REQ-041 IFB full, then s_ifb_pop_i pulsed once -> exactly one new request at the next PC in the pop cycle.
REQ-042 Two fetches in flight, redirect to 0x2000 -> both responses discarded, no push, next request 0x2000.
REQ-043 Error response at 0x108 -> push with status FETCH_BSERR, state HOLD, no requests until redirect.
REQ-044 PC 0xFFFFFFFC granted -> next s_bus_addr_o is 0x00000000.
REQ-045 IFB_CHECKSUM_EN defined, rdata 0x00000013 -> s_checksum_o equals secded_encode output; without the macro, s_checksum_o is 0.
